serial_adder: RTL and testbench

Bit-serial N-bit adder that drives one half-adder pair per clock, with a registered carry. It sits upstream of the half-adder cell: it feeds the cell one operand bit pair per cycle and consumes the cell's sum and carry bits. It then assembles them into a full-width result, trading WIDTH cycles of latency for a single-bit datapath. Operands enter and the result leaves through valid/ready handshakes.

---
 rtl/serial_adder_if.sv | 32 +++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Handshake bundle for serial_adder.
//   Operand side : in_valid / in_ready with operands a, b.
//   Result side  : out_valid / out_ready with sum, carry_out.
//   Status       : busy (an operation is in flight or its result is pending).
//   Modports     : slave  - the adder itself
//                  master - whatever drives operands and consumes results
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit unsigned adder. One operand bit pair is added per
//   clock through two cascaded half-adder stages with a registered carry, so
//   a full add takes WIDTH cycles of latency on a single-bit datapath.
//
//   Ports
//     clk    : sole clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : serial_adder_if.slave
//              in_valid/in_ready + a/b    operand handshake (accepted in IDLE)
//              out_valid/out_ready        result handshake (offered in DONE)
//              sum, carry_out             {carry_out, sum} = a + b
//              busy                       high in SHIFT or DONE
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               c_reg_q,  c_reg_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  // Full add of the current LSB pair, built as two half-adder stages.
  logic s1, k1, s, k2, c_next;

  always_comb begin
    s1     = a_sh_q[0] ^ b_sh_q[0];
    k1     = a_sh_q[0] & b_sh_q[0];
    s      = s1 ^ c_reg_q;
    k2     = s1 & c_reg_q;
    c_next = k1 | k2;
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    c_reg_d  = c_reg_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_reg_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = {s, res_sh_q[WIDTH-1:1]};
        c_reg_d  = c_next;
        cnt_d    = cnt_q + CNT_W'(1);
        // This edge produces the last bit when cnt is about to reach WIDTH.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Result registers are simply held; release only on the consumer's
        // accept. IDLE is entered first, so no operand is taken this edge.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, because sum and carry_out
      // expose them directly and must read zero out of reset.
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      c_reg_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      c_reg_q  <= c_reg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = res_sh_q;
  assign bus.carry_out = c_reg_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder (WIDTH = 8). A transaction-level model
//   tracks "idle / cycles since acceptance / result = a + b" and a per-cycle
//   compare process checks the handshake and result outputs against it.
//   Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model: an accepted pair produces (a+b) exactly W cycles later
  // and holds it until out_ready is seen.
  // ---------------------------------------------------------------------------
  logic         m_idle  = 1'b1;
  int           m_age   = 0;
  logic [W:0]   m_res   = '0;
  logic         m_fresh = 1'b1;   // no operation since reset: outputs read zero

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  = 1'b1;
      m_age   = 0;
      m_res   = '0;
      m_fresh = 1'b1;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle  = 1'b0;
        m_age   = 0;
        m_res   = {1'b0, bus.a} + {1'b0, bus.b};
        m_fresh = 1'b0;
      end
    end else if (m_age < W) begin
      m_age = m_age + 1;
    end else if (bus.out_ready) begin
      m_idle = 1'b1;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready",  bus.in_ready,  1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      check("rst_sum",       bus.sum,       '0);
      check("rst_carry",     bus.carry_out, 1'b0);
    end else begin
      check("cmp_in_ready",  bus.in_ready,  m_idle);
      check("cmp_busy",      bus.busy,      !m_idle);
      check("cmp_out_valid", bus.out_valid, !m_idle && (m_age == W));
      if (!m_idle && (m_age == W)) begin
        check("cmp_sum",   bus.sum,       m_res[W-1:0]);
        check("cmp_carry", bus.carry_out, m_res[W]);
      end
      if (m_fresh) begin
        check("cmp_fresh_sum",   bus.sum,       '0);
        check("cmp_fresh_carry", bus.carry_out, 1'b0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------

  // in_valid must already be high; returns the cycle number seen on the
  // falling edge just before the accepting rising edge.
  task automatic wait_accept(output int acc);
    logic found;
    found = 1'b0;
    acc   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        found = 1'b1;
        acc   = cyc;
        break;
      end
    end
    check("accept_seen", found, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Returns the falling-edge cycle on which out_valid is first seen and the
  // {carry_out, sum} presented there.
  task automatic wait_result(output int vcyc, output logic [W:0] res);
    logic found;
    found = 1'b0;
    vcyc  = 0;
    res   = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        vcyc  = cyc;
        res   = {bus.carry_out, bus.sum};
        break;
      end
    end
    check("result_seen", found, 1'b1);
  endtask

  // One complete operation with out_ready high; compares latency and result
  // with literal expectations.
  task automatic do_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W:0] exp);
    int         acc;
    int         vcyc;
    logic [W:0] res;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    wait_accept(acc);
    bus.in_valid = 1'b0;
    bus.a        = ~av;   // operands may change once accepted
    bus.b        = ~bv;
    check({name, "_model"}, m_res, exp);
    wait_result(vcyc, res);
    check({name, "_latency"}, vcyc - (acc + 1), W);
    check({name, "_result"}, res, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int         acc1, acc2, vcyc;
    int         valid_cnt;
    logic [W:0] res;

    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_sum",      bus.sum,      8'h00);
    @(posedge clk);
    #1;

    // Zero operands and full carry ripple.
    do_op("zero",   8'h00, 8'h00, 9'h000);
    do_op("ripple", 8'hFF, 8'h01, 9'h100);

    // Back-to-back: second pair presented as soon as the first is accepted.
    bus.in_valid = 1'b1;
    bus.a        = 8'hA5;
    bus.b        = 8'h5A;
    wait_accept(acc1);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    wait_result(vcyc, res);
    check("b2b_first_result",  res, 9'h0FF);
    check("b2b_first_latency", vcyc - (acc1 + 1), W);
    wait_accept(acc2);
    bus.in_valid = 1'b0;
    check("b2b_interval", acc2 - acc1, W + 2);
    wait_result(vcyc, res);
    check("b2b_second_result", res, 9'h1FE);
    @(posedge clk);
    #1;

    // Back-pressure: out_ready low for 5 cycles of out_valid.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h3C;
    bus.b         = 8'h4B;
    wait_accept(acc1);
    bus.in_valid = 1'b0;
    wait_result(vcyc, res);
    check("bp_result", res, 9'h087);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready",  bus.in_ready,  1'b0);
      check("bp_hold",      {bus.carry_out, bus.sum}, 9'h087);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", bus.out_valid, 1'b0);
    check("bp_released_ready", bus.in_ready,  1'b1);
    @(posedge clk);
    #1;

    // in_valid pulsed mid-operation is ignored.
    bus.in_valid = 1'b1;
    bus.a        = 8'h0F;
    bus.b        = 8'h01;
    wait_accept(acc1);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = 8'h11;
    bus.b        = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result(vcyc, res);
    check("ignore_result",  res, 9'h010);
    check("ignore_latency", vcyc - (acc1 + 1), W);
    @(posedge clk);
    #1;

    // Reset in the third SHIFT cycle aborts the operation.
    bus.in_valid = 1'b1;
    bus.a        = 8'h12;
    bus.b        = 8'h34;
    wait_accept(acc1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_busy",      bus.busy,      1'b0);
    check("abort_in_ready",  bus.in_ready,  1'b1);
    check("abort_sum",       bus.sum,       8'h00);
    check("abort_carry",     bus.carry_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    valid_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) valid_cnt = valid_cnt + 1;
    end
    check("abort_no_valid", valid_cnt, 0);
    @(posedge clk);
    #1;
    do_op("after_abort", 8'h80, 8'h80, 9'h100);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
